// File: rtl/baud_rate_gen.sv
// Baud-rate selector and 16x oversample tick generator.
// A table of up to four divisors is indexed by rate_idx. The index advances on
// a synchronised rising edge of the selbaud push-button, or is loaded directly
// with set_en/set_idx. A free-running counter, cleared on every rate change,
// produces a one-cycle tick every refer+1 cycles while en is high.
module baud_rate_gen #(
    parameter int CNT_W  = 12,
    parameter int NRATES = 3,
    parameter int DIV0   = 324,
    parameter int DIV1   = 53,
    parameter int DIV2   = 26,
    parameter int DIV3   = 161
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             selbaud,
    input  logic             set_en,
    input  logic [1:0]       set_idx,
    input  logic             en,
    output logic [CNT_W-1:0] refer,
    output logic [1:0]       rate_idx,
    output logic             tick,
    output logic             rate_chg
);

    // Table size and last valid index, sized for direct comparison with the 2-bit index.
    localparam logic [2:0] NR   = 3'(NRATES);
    localparam logic [1:0] LAST = 2'(NRATES - 1);

    logic             s1_q, s2_q, s3_q;
    logic [1:0]       idx_q, idx_d;
    logic             chg_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             step, load_ok, accept;

    // Two-flop synchroniser for the push-button plus a delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= selbaud;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign step    = s2_q & ~s3_q;
    // Out-of-range loads are dropped entirely (no index change, no rate_chg).
    assign load_ok = set_en & ({1'b0, set_idx} < NR);
    assign accept  = step | load_ok;

    // Next index: a valid direct load overrides a coincident step.
    always_comb begin
        idx_d = idx_q;
        if (load_ok)
            idx_d = set_idx;
        else if (step)
            idx_d = (idx_q == LAST) ? 2'd0 : idx_q + 2'd1;
    end

    // Rate index register and one-cycle change pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= 2'd0;
            chg_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            chg_q <= accept;
        end
    end

    // Divisor decode of the current index.
    always_comb begin
        refer = CNT_W'(DIV3);
        case (idx_q)
            2'd0:    refer = CNT_W'(DIV0);
            2'd1:    refer = CNT_W'(DIV1);
            2'd2:    refer = CNT_W'(DIV2);
            default: refer = CNT_W'(DIV3);
        endcase
    end

    // Tick counter: a rate change or disable restarts the period from zero.
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        tick_d = 1'b0;
        if (accept || !en) begin
            cnt_d  = '0;
            tick_d = 1'b0;
        end else if (cnt_q == refer) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    // Counter and registered tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign rate_idx = idx_q;
    assign rate_chg = chg_q;
    assign tick     = tick_q;

endmodule

// File: tb/tb_baud_rate_gen.sv
// Directed bench for baud_rate_gen with default parameters (NRATES=3).
module tb_baud_rate_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        selbaud = 1'b0;
    logic        set_en = 1'b0;
    logic [1:0]  set_idx = 2'd0;
    logic        en = 1'b1;
    logic [11:0] refer;
    logic [1:0]  rate_idx;
    logic        tick;
    logic        rate_chg;

    int checks = 0;
    int errors = 0;
    int chg_cnt = 0;

    baud_rate_gen dut (
        .clk(clk), .rst(rst), .selbaud(selbaud), .set_en(set_en),
        .set_idx(set_idx), .en(en), .refer(refer), .rate_idx(rate_idx),
        .tick(tick), .rate_chg(rate_chg)
    );

    always #5 clk = ~clk;

    // Count rate_chg pulses away from the active edge.
    always @(negedge clk) if (rate_chg) chg_cnt++;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Count edges until tick is seen high (sampled 1 time unit after each edge).
    task automatic wait_tick(output int edges);
        edges = 0;
        while (edges < 1000) begin
            @(posedge clk); #1;
            edges++;
            if (tick) break;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One button press held 5 samples; checks the 2-edge latency and a single pulse.
    task automatic press(input int old_idx, input int exp_idx, input int exp_ref);
        int c0;
        c0 = chg_cnt;
        selbaud = 1'b1;
        cyc(2);
        chk("press_lat_k1", rate_idx, old_idx);
        cyc(1);
        chk("press_idx", rate_idx, exp_idx);
        chk("press_refer", refer, exp_ref);
        chk("press_chg", rate_chg, 1);
        cyc(2);
        selbaud = 1'b0;
        cyc(5);
        chk("press_one_pulse", chg_cnt - c0, 1);
    endtask

    initial begin
        int e, c0, tk;

        // Reset values, including across a clock edge while held.
        #2;
        chk("rst_idx", rate_idx, 0);
        chk("rst_refer", refer, 324);
        chk("rst_tick", tick, 0);
        chk("rst_chg", rate_chg, 0);
        #6 rst = 1'b1;  // release at t=8, first counted edge at t=15

        // Free-running period at index 0.
        c0 = chg_cnt;
        wait_tick(e); chk("first_tick", e, 325);
        wait_tick(e); chk("period0", e, 325);
        chk("no_chg_idle", chg_cnt - c0, 0);

        // Three presses wrap 0->1->2->0.
        press(0, 1, 53);
        press(1, 2, 26);
        press(2, 0, 324);

        // Index 2 period, then a press mid-count restarts at index 0.
        press(0, 1, 53);
        press(1, 2, 26);
        wait_tick(e);
        wait_tick(e); chk("period2", e, 27);
        cyc(10);
        selbaud = 1'b1;
        cyc(3);
        chk("mid_press_idx", rate_idx, 0);
        wait_tick(e); chk("period_after_change", e, 325);
        selbaud = 1'b0;
        cyc(5);

        // Direct loads.
        set_en = 1'b1; set_idx = 2'd1;
        cyc(1); set_en = 1'b0;
        chk("load1_idx", rate_idx, 1);
        chk("load1_chg", rate_chg, 1);
        chk("load1_refer", refer, 53);
        cyc(1);
        chk("load1_chg_drop", rate_chg, 0);
        set_en = 1'b1; set_idx = 2'd3;
        cyc(1); set_en = 1'b0;
        chk("load3_idx", rate_idx, 1);
        chk("load3_chg", rate_chg, 0);
        set_en = 1'b1; set_idx = 2'd1;
        cyc(1); set_en = 1'b0;
        chk("load_same_chg", rate_chg, 1);
        chk("load_same_idx", rate_idx, 1);
        cyc(2);

        // Load coinciding with a step: load wins, one pulse only.
        c0 = chg_cnt;
        selbaud = 1'b1;
        cyc(2);
        set_en = 1'b1; set_idx = 2'd2;
        cyc(1); set_en = 1'b0;
        chk("coll_idx", rate_idx, 2);
        chk("coll_chg", rate_chg, 1);
        cyc(3);
        selbaud = 1'b0;
        chk("coll_idx_hold", rate_idx, 2);
        cyc(3);
        chk("coll_one_pulse", chg_cnt - c0, 1);

        // Enable drop mid-count.
        wait_tick(e);
        cyc(10);
        en = 1'b0;
        tk = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (tick) tk++;
        end
        chk("en_off_no_tick", tk, 0);
        en = 1'b1;
        wait_tick(e); chk("period_reenable", e, 27);

        // Reset mid-count and mid-synchronisation at index 2.
        cyc(5);
        selbaud = 1'b1;
        cyc(1);
        rst = 1'b0; selbaud = 1'b0;
        #1;
        chk("amid_idx", rate_idx, 0);
        chk("amid_refer", refer, 324);
        chk("amid_tick", tick, 0);
        chk("amid_chg", rate_chg, 0);
        cyc(2);
        #2 rst = 1'b1;
        c0 = chg_cnt;
        wait_tick(e); chk("period_after_rst", e, 325);
        chk("post_rst_idx", rate_idx, 0);
        chk("post_rst_no_chg", chg_cnt - c0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
